// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises a 16-bit sample MSB-first to an AD5541A-style SPI DAC, then pulses LDAC
module dac_spi_tx #(
  parameter int CLK_DIV  = 1,
  parameter int FLIP_MSB = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sig,
  input  logic        sig_valid,
  output logic        sig_ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        dac_ldac_n,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CSHOLD, LOAD} state_t;
  localparam logic [7:0] LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] PENULT = 8'(CLK_DIV - 2);
  localparam logic       FLIP   = 1'(FLIP_MSB);
  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        last;
  assign last = div_cnt == LAST;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      shreg      <= 16'd0;
      sig_ready  <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_din    <= 1'b0;
      dac_ldac_n <= 1'b1;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      div_cnt <= (state == IDLE || last) ? 8'd0 : div_cnt + 8'd1;
      case (state)
        IDLE: begin
          sig_ready <= 1'b1;
          if (sig_valid && sig_ready) begin
            shreg     <= {sig[15] ^ FLIP, sig[14:0]};
            dac_din   <= sig[15] ^ FLIP;
            sig_ready <= 1'b0;
            dac_cs_n  <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (last) begin
            dac_sclk <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (last && dac_sclk) begin
            dac_sclk <= 1'b0;
            dac_din  <= shreg[14];
            shreg    <= {shreg[14:0], 1'b0};
          end else if (last) begin
            bit_cnt  <= bit_cnt + 4'd1;
            dac_sclk <= bit_cnt != 4'd15;
            dac_cs_n <= bit_cnt == 4'd15;
            state    <= bit_cnt == 4'd15 ? CSHOLD : SHIFT;
          end
        end
        CSHOLD: begin
          if (last) begin
            dac_ldac_n <= 1'b0;
            done       <= CLK_DIV == 1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (last) begin
            dac_ldac_n <= 1'b1;
            sig_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            done <= div_cnt == PENULT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
